// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage program counter and single-outstanding IMEM requester.
// Delivers {pc, pc+4, instr} to IF/ID through a valid/ready handshake.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise
// fetch_misalign_o and suppress IMEM requests. Without it, targets are forced word-aligned.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic [XLEN-1:0] instr_q, instr_n;
  logic [XLEN-1:0] ipc_q, ipc_n;
  logic [XLEN-1:0] ipc4_q, ipc4_n;
  logic            kill_q, kill_n;
  logic            mis_q, mis_n;
  logic            req_q, req_n;
  logic            valid_q, valid_n;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] load_pc;
  logic            mis_tgt;
  logic            gnt_acc;

  assign pc_inc  = pc_q + 32'd4;
  assign gnt_acc = imem_gnt_i & req_q;

  // Redirect target as loaded into the PC, and whether it must trap
`ifdef FETCH_MISALIGN_TRAP_EN
  assign load_pc = target_i;
  assign mis_tgt = (target_i[1:0] != 2'b00);
`else
  assign load_pc = target_i & ~32'h0000_0003;
  assign mis_tgt = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      ipc4_q  <= ipc4_n;
      kill_q  <= kill_n;
      mis_q   <= mis_n;
      req_q   <= req_n;
      valid_q <= valid_n;
    end
  end

  // Next-state logic; redirect outranks every other event in each state
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    ipc4_n  = ipc4_q;
    kill_n  = kill_q;
    mis_n   = mis_q;
    valid_n = valid_q;

    case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          pc_n  = load_pc;
          mis_n = mis_tgt;
          if (gnt_acc) begin
            // old address already granted: absorb its response in WAIT
            kill_n  = 1'b1;
            state_n = S_WAIT;
          end
        end else if (gnt_acc) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_n  = load_pc;
          mis_n = mis_tgt;
          if (imem_rvalid_i) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (kill_q) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            instr_n = imem_rdata_i;
            ipc_n   = pc_q;
            ipc4_n  = pc_inc;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_n    = load_pc;
          mis_n   = mis_tgt;
          valid_n = 1'b0;
          state_n = S_REQ;
        end else if (id_ready_i) begin
          pc_n    = pc_inc;
          valid_n = 1'b0;
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  // Request is presented while in REQ, except when a misaligned target is pending
  assign req_n  = (state_n == S_REQ) & ~mis_n;
  assign addr_n = pc_n;

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign if_valid_o    = valid_q;
  assign if_instr_o    = instr_q;
  assign if_pc_o       = ipc_q;
  assign if_pc_plus4_o = ipc4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign_o = mis_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed cycle table, hand-written corner sequences,
// and a randomized run against a transaction-level model of the fetch stream.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic        id_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .id_ready_i    (id_ready_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus4_o (if_pc_plus4_o)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  // One cycle of stimulus and the outputs expected during that cycle
  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tab[$];

  // Instruction memory contents: a bijection of the address, so every word is distinct
  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic rd, input logic [31:0] tg, input logic g,
                              input logic rv, input logic [31:0] rdat, input logic ry,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.redir = rd; v.tgt = tg; v.gnt = g; v.rv = rv; v.rdata = rdat; v.rdy = ry;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic add(input logic rd, input logic [31:0] tg, input logic g,
                     input logic rv, input logic [31:0] rdat, input logic ry,
                     input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep);
    tab.push_back(mk(rd, tg, g, rv, rdat, ry, er, ea, ev, ep));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // At a negedge: compare current outputs, drive inputs for the next posedge, advance
  task automatic apply_vec(input vec_t v, input string tag);
    chk({tag, ".req"},   32'(imem_req_o), 32'(v.e_req));
    chk({tag, ".addr"},  imem_addr_o, v.e_addr);
    chk({tag, ".valid"}, 32'(if_valid_o), 32'(v.e_valid));
    if (v.e_valid) begin
      chk({tag, ".pc"},    if_pc_o, v.e_pc);
      chk({tag, ".instr"}, if_instr_o, ins(v.e_pc));
      chk({tag, ".pc4"},   if_pc_plus4_o, v.e_pc + 32'd4);
    end
    redirect_i    = v.redir;
    target_i      = v.tgt;
    imem_gnt_i    = v.gnt;
    imem_rvalid_i = v.rv;
    imem_rdata_i  = v.rdata;
    id_ready_i    = v.rdy;
    @(negedge clk);
  endtask

  // Hold reset for two edges, check reset outputs, release at a negedge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    redirect_i = 1'b0; target_i = 32'h0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; id_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".req"},   32'(imem_req_o), 32'h0);
    chk({tag, ".valid"}, 32'(if_valid_o), 32'h0);
    chk({tag, ".instr"}, if_instr_o, 32'h0000_0013);
    chk({tag, ".pc"},    if_pc_o, 32'h0);
    chk({tag, ".pc4"},   if_pc_plus4_o, 32'h0);
    chk({tag, ".addr"},  imem_addr_o, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, ".mis"},   32'(fetch_misalign_o), 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] e_pc;
    logic [31:0] pend_addr;
    logic [31:0] p_tgt, p_pc, p_instr;
    logic        pend, p_redir, p_valid, p_rdy;
    int unsigned cnt;
    int          consumed;

    // Directed cycle table starting at the first cycle after reset release
    add(L,32'h0,L,L,32'h0,H,             L,32'h0,L,32'h0);
    add(L,32'h0,H,L,32'h0,H,             H,32'h100,L,32'h0);
    add(L,32'h0,L,H,ins(32'h100),H,      L,32'h100,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'h100,H,32'h100);
    add(L,32'h0,H,L,32'h0,H,             H,32'h104,L,32'h0);
    add(L,32'h0,L,H,ins(32'h104),H,      L,32'h104,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'h104,H,32'h104);
    add(L,32'h0,H,L,32'h0,H,             H,32'h108,L,32'h0);
    add(L,32'h0,L,H,ins(32'h108),H,      L,32'h108,L,32'h0);
    for (int i = 0; i < 6; i++)
      add(L,32'h0,L,L,32'h0,L,           L,32'h108,H,32'h108);
    add(L,32'h0,L,L,32'h0,H,             L,32'h108,H,32'h108);
    for (int i = 0; i < 4; i++)
      add(L,32'h0,L,L,32'h0,H,           H,32'h10C,L,32'h0);
    add(L,32'h0,H,L,32'h0,H,             H,32'h10C,L,32'h0);
    add(L,32'h0,L,H,ins(32'h10C),H,      L,32'h10C,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'h10C,H,32'h10C);
    add(L,32'h0,H,L,32'h0,H,             H,32'h110,L,32'h0);
    add(H,32'h200,L,L,32'h0,H,           L,32'h110,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'h200,L,32'h0);
    add(L,32'h0,L,H,ins(32'h110),H,      L,32'h200,L,32'h0);
    add(L,32'h0,H,L,32'h0,H,             H,32'h200,L,32'h0);
    add(L,32'h0,L,H,ins(32'h200),H,      L,32'h200,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'h200,H,32'h200);
    add(H,32'hFFFF_FFFC,L,L,32'h0,H,     H,32'h204,L,32'h0);
    add(L,32'h0,H,L,32'h0,H,             H,32'hFFFF_FFFC,L,32'h0);
    add(L,32'h0,L,H,ins(32'hFFFF_FFFC),H,L,32'hFFFF_FFFC,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'hFFFF_FFFC,H,32'hFFFF_FFFC);
    add(H,32'h300,H,L,32'h0,H,           H,32'h0,L,32'h0);
    add(L,32'h0,L,H,ins(32'h0),H,        L,32'h300,L,32'h0);
    add(L,32'h0,H,L,32'h0,L,             H,32'h300,L,32'h0);
    add(L,32'h0,L,H,ins(32'h300),L,      L,32'h300,L,32'h0);
    add(H,32'h400,L,L,32'h0,H,           L,32'h300,H,32'h300);
    add(L,32'h0,H,L,32'h0,H,             H,32'h400,L,32'h0);
    add(L,32'h0,L,H,ins(32'h400),H,      L,32'h400,L,32'h0);
    add(L,32'h0,L,L,32'h0,H,             L,32'h400,H,32'h400);

    do_reset("rst0");
    foreach (tab[i]) apply_vec(tab[i], $sformatf("v%0d", i));

    // Misaligned redirect target 0x202
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis.pre", 32'(fetch_misalign_o), 32'h0);
    apply_vec(mk(H,32'h202,L,L,32'h0,L, H,32'h404,L,32'h0), "mis.a");
    for (int i = 0; i < 3; i++) begin
      chk("mis.set", 32'(fetch_misalign_o), 32'h1);
      apply_vec(mk(L,32'h0,L,L,32'h0,L, L,32'h202,L,32'h0), "mis.b");
    end
    chk("mis.hold", 32'(fetch_misalign_o), 32'h1);
    apply_vec(mk(H,32'h300,L,L,32'h0,L, L,32'h202,L,32'h0), "mis.c");
    chk("mis.clr", 32'(fetch_misalign_o), 32'h0);
    apply_vec(mk(L,32'h0,H,L,32'h0,L, H,32'h300,L,32'h0), "mis.d");
`else
    apply_vec(mk(H,32'h202,L,L,32'h0,L, H,32'h404,L,32'h0), "mis.a");
    apply_vec(mk(L,32'h0,H,L,32'h0,L, H,32'h200,L,32'h0), "mis.b");
    apply_vec(mk(L,32'h0,L,H,ins(32'h200),L, L,32'h200,L,32'h0), "mis.c");
    apply_vec(mk(L,32'h0,L,L,32'h0,H, L,32'h200,H,32'h200), "mis.d");
    apply_vec(mk(L,32'h0,H,L,32'h0,L, H,32'h204,L,32'h0), "mis.e");
`endif

    // Reset with a grant outstanding; its response is never delivered
    do_reset("rst1");

    // Randomized run against a transaction-level model of the expected fetch stream
    e_pc = RST_PC; pend = 1'b0; pend_addr = 32'h0; cnt = 0; consumed = 0;
    p_redir = 1'b0; p_valid = 1'b0; p_rdy = 1'b0;
    p_tgt = 32'h0; p_pc = 32'h0; p_instr = 32'h0;
    for (int k = 0; k < 2500; k++) begin
      // Advance the model by what happened at the last edge
      if (p_redir) begin
        e_pc = p_tgt & 32'hFFFF_FFFC;
      end else if (p_valid && p_rdy) begin
        e_pc = e_pc + 32'd4;
        consumed++;
      end
      if (if_valid_o) begin
        chk("rnd.pc",    if_pc_o, e_pc);
        chk("rnd.instr", if_instr_o, ins(e_pc));
        chk("rnd.pc4",   if_pc_plus4_o, e_pc + 32'd4);
      end
      if (p_valid && !p_rdy && !p_redir) begin
        chk("rnd.stall_valid", 32'(if_valid_o), 32'h1);
        chk("rnd.stall_pc",    if_pc_o, p_pc);
        chk("rnd.stall_instr", if_instr_o, p_instr);
      end
      if (imem_req_o) begin
        chk("rnd.addr",   imem_addr_o, e_pc);
        chk("rnd.single", 32'(pend), 32'h0);
      end
      p_valid = if_valid_o; p_pc = if_pc_o; p_instr = if_instr_o;

      // IMEM: one outstanding access, random grant delay and response latency
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = ins(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (imem_req_o && $urandom_range(0, 9) < 6) begin
        imem_gnt_i = 1'b1;
        pend = 1'b1;
        pend_addr = imem_addr_o;
        cnt = $urandom_range(0, 2);
      end

      redirect_i = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 15) == 0)
        target_i = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      else
        target_i = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
`ifndef FETCH_MISALIGN_TRAP_EN
      target_i = target_i | $urandom_range(0, 3);
`endif
      id_ready_i = ($urandom_range(0, 99) < 70);
      p_redir = redirect_i; p_tgt = target_i; p_rdy = id_ready_i;
      @(negedge clk);
    end
    chk("rnd.progress", 32'(consumed >= 100), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
